// File: rtl/fifo_pkg.sv
// -----------------------------------------------------------------------------
// fifo_pkg
// Shared definitions for the synchronous FIFO:
//   - read-mode encodings selected by the FWFT parameter
//   - helpers deriving depth and pointer width from the address width
// -----------------------------------------------------------------------------
package fifo_pkg;

  // Read-port behaviour. STD returns the popped word one cycle after the read;
  // FALL (first-word-fall-through) always presents the head word.
  typedef enum logic {
    FWFT_STD  = 1'b0,
    FWFT_FALL = 1'b1
  } fwft_mode_e;

  // Number of storage entries for a given address width.
  function automatic int fifo_depth(input int addr_len);
    return 1 << addr_len;
  endfunction

  // Pointers carry one extra wrap bit so full and empty can be told apart
  // when the address bits are equal.
  function automatic int fifo_ptr_w(input int addr_len);
    return addr_len + 1;
  endfunction

endpackage

// File: rtl/fifo_mem.sv
// -----------------------------------------------------------------------------
// fifo_mem
// Register-array storage for sync_fifo: DEPTH x DATA_LEN words, one
// synchronous write port and one asynchronous (combinational) read port.
// The array is deliberately not reset; the control logic in sync_fifo decides
// which entries are meaningful.
//
// Ports:
//   clk      in   write clock (rising edge)
//   i_we     in   write enable
//   i_waddr  in   write address
//   i_wdata  in   write word
//   i_raddr  in   read address
//   o_rdata  out  word stored at i_raddr
// -----------------------------------------------------------------------------
module fifo_mem
  import fifo_pkg::*;
#(
  parameter int DATA_LEN = 8,
  parameter int ADDR_LEN = 3
) (
  input  logic                clk,
  input  logic                i_we,
  input  logic [ADDR_LEN-1:0] i_waddr,
  input  logic [DATA_LEN-1:0] i_wdata,
  input  logic [ADDR_LEN-1:0] i_raddr,
  output logic [DATA_LEN-1:0] o_rdata
);

  localparam int DEPTH = fifo_depth(ADDR_LEN);

  logic [DATA_LEN-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/sync_fifo.sv
// -----------------------------------------------------------------------------
// sync_fifo
// Single-clock FIFO with registered status flags, sticky error flags, flush,
// and a choice of standard (registered) or first-word-fall-through read port.
//
// Parameters:
//   DATA_LEN   word width
//   ADDR_LEN   address width, DEPTH = 2**ADDR_LEN
//   FWFT       0 = standard registered read, 1 = first-word-fall-through
//   AF_THRESH  almost_full when count >= AF_THRESH
//   AE_THRESH  almost_empty when count <= AE_THRESH
//
// Ports:
//   clk           in   clock, rising edge
//   rst           in   synchronous active-high reset, overrides everything
//   flush         in   discard all stored entries
//   wr_en/wr_data in   write request / word
//   rd_en         in   read request (pops head word in FWFT mode)
//   err_clr       in   clear sticky overflow/underflow
//   rd_data       out  read word
//   rd_valid      out  rd_data valid
//   full, empty, almost_full, almost_empty  out  registered status flags
//   count         out  occupancy 0..DEPTH
//   overflow, underflow  out  sticky error flags
// -----------------------------------------------------------------------------
module sync_fifo
  import fifo_pkg::*;
#(
  parameter int DATA_LEN  = 8,
  parameter int ADDR_LEN  = 3,
  parameter int FWFT      = 0,
  parameter int AF_THRESH = (1 << ADDR_LEN) - 1,
  parameter int AE_THRESH = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                flush,
  input  logic                wr_en,
  input  logic [DATA_LEN-1:0] wr_data,
  input  logic                rd_en,
  input  logic                err_clr,
  output logic [DATA_LEN-1:0] rd_data,
  output logic                rd_valid,
  output logic                full,
  output logic                empty,
  output logic                almost_full,
  output logic                almost_empty,
  output logic [ADDR_LEN:0]   count,
  output logic                overflow,
  output logic                underflow
);

  localparam int                DEPTH = fifo_depth(ADDR_LEN);
  localparam int                PTR_W = fifo_ptr_w(ADDR_LEN);
  localparam fwft_mode_e        MODE  = (FWFT != 0) ? FWFT_FALL : FWFT_STD;
  localparam logic [PTR_W-1:0]  ONE   = PTR_W'(1);
  localparam logic [PTR_W-1:0]  AF_T  = PTR_W'(AF_THRESH);
  localparam logic [PTR_W-1:0]  AE_T  = PTR_W'(AE_THRESH);

  logic [PTR_W-1:0]    r_wr_ptr;
  logic [PTR_W-1:0]    r_rd_ptr;
  logic [PTR_W-1:0]    r_count;
  logic                r_full;
  logic                r_empty;
  logic                r_almost_full;
  logic                r_almost_empty;
  logic                r_overflow;
  logic                r_underflow;

  logic                w_wr_acc;
  logic                w_rd_acc;
  logic                w_mem_we;
  logic [PTR_W-1:0]    w_wr_ptr_nxt;
  logic [PTR_W-1:0]    w_rd_ptr_nxt;
  logic [PTR_W-1:0]    w_count_nxt;
  logic                w_full_nxt;
  logic                w_empty_nxt;
  logic [DATA_LEN-1:0] w_head;

  // Acceptance uses only registered flags, so no input reaches a status flag
  // without passing through a register. Flush discards concurrent requests.
  assign w_wr_acc = wr_en && !r_full  && !flush;
  assign w_rd_acc = rd_en && !r_empty && !flush;
  assign w_mem_we = w_wr_acc && !rst;

  // ---------------------------------------------------------------------------
  // Storage
  // ---------------------------------------------------------------------------
  fifo_mem #(
    .DATA_LEN (DATA_LEN),
    .ADDR_LEN (ADDR_LEN)
  ) u_mem (
    .clk     (clk),
    .i_we    (w_mem_we),
    .i_waddr (r_wr_ptr[ADDR_LEN-1:0]),
    .i_wdata (wr_data),
    .i_raddr (r_rd_ptr[ADDR_LEN-1:0]),
    .o_rdata (w_head)
  );

  // ---------------------------------------------------------------------------
  // Next-state pointers and occupancy
  // ---------------------------------------------------------------------------
  always_comb begin
    w_wr_ptr_nxt = r_wr_ptr;
    w_rd_ptr_nxt = r_rd_ptr;
    w_count_nxt  = r_count;
    if (flush) begin
      w_wr_ptr_nxt = '0;
      w_rd_ptr_nxt = '0;
      w_count_nxt  = '0;
    end else begin
      // The extra wrap bit toggles naturally when the low bits roll over.
      if (w_wr_acc) w_wr_ptr_nxt = r_wr_ptr + ONE;
      if (w_rd_acc) w_rd_ptr_nxt = r_rd_ptr + ONE;
      case ({w_wr_acc, w_rd_acc})
        2'b10:   w_count_nxt = r_count + ONE;
        2'b01:   w_count_nxt = r_count - ONE;
        default: w_count_nxt = r_count;
      endcase
    end
  end

  assign w_empty_nxt = (w_wr_ptr_nxt == w_rd_ptr_nxt);
  assign w_full_nxt  = (w_wr_ptr_nxt[ADDR_LEN-1:0] == w_rd_ptr_nxt[ADDR_LEN-1:0]) &&
                       (w_wr_ptr_nxt[ADDR_LEN] != w_rd_ptr_nxt[ADDR_LEN]);

  // ---------------------------------------------------------------------------
  // Registered pointers, count and status flags
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr       <= '0;
      r_rd_ptr       <= '0;
      r_count        <= '0;
      r_empty        <= 1'b1;
      r_full         <= 1'b0;
      r_almost_full  <= 1'b0;
      r_almost_empty <= 1'b1;
    end else begin
      r_wr_ptr       <= w_wr_ptr_nxt;
      r_rd_ptr       <= w_rd_ptr_nxt;
      r_count        <= w_count_nxt;
      r_empty        <= w_empty_nxt;
      r_full         <= w_full_nxt;
      r_almost_full  <= (w_count_nxt >= AF_T);
      r_almost_empty <= (w_count_nxt <= AE_T);
    end
  end

  // ---------------------------------------------------------------------------
  // Sticky error flags: a new error wins over err_clr; flush neither sets
  // nor clears them.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      if (wr_en && r_full && !flush) begin
        r_overflow <= 1'b1;
      end else if (err_clr) begin
        r_overflow <= 1'b0;
      end
      if (rd_en && r_empty && !flush) begin
        r_underflow <= 1'b1;
      end else if (err_clr) begin
        r_underflow <= 1'b0;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Read port
  // ---------------------------------------------------------------------------
  if (MODE == FWFT_STD) begin : g_std_read
    logic [DATA_LEN-1:0] r_rd_data;
    logic                r_rd_valid;

    // Popped word appears the cycle after the read; rd_data holds otherwise.
    always_ff @(posedge clk) begin
      if (rst) begin
        r_rd_data  <= '0;
        r_rd_valid <= 1'b0;
      end else if (w_rd_acc) begin
        r_rd_data  <= w_head;
        r_rd_valid <= 1'b1;
      end else begin
        r_rd_valid <= 1'b0;
      end
    end

    assign rd_data  = r_rd_data;
    assign rd_valid = r_rd_valid;
  end else begin : g_fwft_read
    // Head word is presented straight from storage. When empty the output is
    // forced to zero so unreset storage never leaks out after reset.
    assign rd_data  = r_empty ? '0 : w_head;
    assign rd_valid = !r_empty;
  end

  assign full         = r_full;
  assign empty        = r_empty;
  assign almost_full  = r_almost_full;
  assign almost_empty = r_almost_empty;
  assign count        = r_count;
  assign overflow     = r_overflow;
  assign underflow    = r_underflow;

endmodule

// File: tb/tb_sync_fifo.sv
// -----------------------------------------------------------------------------
// tb_sync_fifo
// Drives one standard-read and one FWFT instance with identical stimulus and
// compares both against a queue-based reference model every cycle.
// -----------------------------------------------------------------------------
module tb_sync_fifo;

  logic       clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, flush, wr_en, rd_en, err_clr;
  logic [7:0] wr_data;

  logic [7:0] rd_data_s, rd_data_f;
  logic       rd_valid_s, rd_valid_f;
  logic       full_s, empty_s, af_s, ae_s, ovf_s, unf_s;
  logic       full_f, empty_f, af_f, ae_f, ovf_f, unf_f;
  logic [3:0] count_s, count_f;

  sync_fifo #(.DATA_LEN(8), .ADDR_LEN(3), .FWFT(0)) u_std (
    .clk(clk), .rst(rst), .flush(flush), .wr_en(wr_en), .wr_data(wr_data),
    .rd_en(rd_en), .err_clr(err_clr), .rd_data(rd_data_s), .rd_valid(rd_valid_s),
    .full(full_s), .empty(empty_s), .almost_full(af_s), .almost_empty(ae_s),
    .count(count_s), .overflow(ovf_s), .underflow(unf_s));

  sync_fifo #(.DATA_LEN(8), .ADDR_LEN(3), .FWFT(1)) u_fwft (
    .clk(clk), .rst(rst), .flush(flush), .wr_en(wr_en), .wr_data(wr_data),
    .rd_en(rd_en), .err_clr(err_clr), .rd_data(rd_data_f), .rd_valid(rd_valid_f),
    .full(full_f), .empty(empty_f), .almost_full(af_f), .almost_empty(ae_f),
    .count(count_f), .overflow(ovf_f), .underflow(unf_f));

  int    total = 0;
  int    bad   = 0;
  string phase = "init";

  // Reference model
  logic [7:0] q[$];
  bit         m_ovf, m_unf, m_rv;
  logic [7:0] m_rd;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s/%s observed=%0h expected=%0h", phase, tag, obs, exp);
    end
  endtask

  task automatic check_all();
    int n;
    n = q.size();
    chk("count_s", 32'(count_s), n);
    chk("empty_s", 32'(empty_s), (n == 0));
    chk("full_s",  32'(full_s),  (n == 8));
    chk("af_s",    32'(af_s),    (n >= 7));
    chk("ae_s",    32'(ae_s),    (n <= 1));
    chk("ovf_s",   32'(ovf_s),   32'(m_ovf));
    chk("unf_s",   32'(unf_s),   32'(m_unf));
    chk("rvalid_s", 32'(rd_valid_s), 32'(m_rv));
    chk("rdata_s", 32'(rd_data_s), 32'(m_rd));
    chk("count_f", 32'(count_f), n);
    chk("empty_f", 32'(empty_f), (n == 0));
    chk("full_f",  32'(full_f),  (n == 8));
    chk("ovf_f",   32'(ovf_f),   32'(m_ovf));
    chk("unf_f",   32'(unf_f),   32'(m_unf));
    chk("rvalid_f", 32'(rd_valid_f), (n != 0));
    if (n != 0) chk("rdata_f", 32'(rd_data_f), 32'(q[0]));
  endtask

  // One clock: apply inputs, advance the model at the edge, check 1ns later.
  task automatic step(input bit w, input logic [7:0] d, input bit r,
                      input bit f, input bit ec, input bit rs);
    bit was_full, was_empty;
    wr_en = w; wr_data = d; rd_en = r; flush = f; err_clr = ec; rst = rs;
    @(posedge clk);
    was_full  = (q.size() == 8);
    was_empty = (q.size() == 0);
    if (rs) begin
      q.delete();
      m_ovf = 0; m_unf = 0; m_rv = 0; m_rd = 8'h00;
    end else if (f) begin
      q.delete();
      m_rv = 0;
      if (ec) begin m_ovf = 0; m_unf = 0; end
    end else begin
      if (r && !was_empty) begin
        m_rd = q.pop_front();
        m_rv = 1;
      end else begin
        m_rv = 0;
      end
      if (w && !was_full) q.push_back(d);
      if (w && was_full) m_ovf = 1; else if (ec) m_ovf = 0;
      if (r && was_empty) m_unf = 1; else if (ec) m_unf = 0;
    end
    #1;
    check_all();
  endtask

  initial begin
    rst = 1; flush = 0; wr_en = 0; rd_en = 0; err_clr = 0; wr_data = 8'h00;
    m_ovf = 0; m_unf = 0; m_rv = 0; m_rd = 8'h00;

    phase = "reset";
    step(0, 8'h00, 0, 0, 0, 1);
    step(0, 8'h00, 0, 0, 0, 1);
    chk("rdata_s_rst", 32'(rd_data_s), 0);
    chk("rdata_f_rst", 32'(rd_data_f), 0);
    step(0, 8'h00, 0, 0, 0, 0);

    phase = "single";
    step(1, 8'hA5, 0, 0, 0, 0);
    chk("count_after_wr", 32'(count_s), 1);
    step(0, 8'h00, 1, 0, 0, 0);
    chk("a5_valid", 32'(rd_valid_s), 1);
    chk("a5_data", 32'(rd_data_s), 32'hA5);
    chk("a5_empty", 32'(empty_s), 1);
    step(0, 8'h00, 0, 0, 0, 0);
    chk("a5_pulse_end", 32'(rd_valid_s), 0);

    phase = "fill";
    for (int i = 0; i < 12; i++) step(1, 8'(8'h10 + i), 0, 0, 0, 0);
    chk("fill_ovf", 32'(ovf_s), 1);
    chk("fill_count", 32'(count_s), 8);

    phase = "drain";
    for (int i = 0; i < 11; i++) begin
      step(0, 8'h00, 1, 0, 0, 0);
      if (i < 8) chk("drain_order", 32'(rd_data_s), 32'(8'h10 + i));
    end
    chk("drain_unf", 32'(unf_s), 1);

    phase = "set_wins";
    step(0, 8'h00, 1, 0, 1, 0);
    chk("unf_kept", 32'(unf_s), 1);
    step(0, 8'h00, 0, 0, 1, 0);

    phase = "steady";
    for (int i = 0; i < 4; i++) step(1, 8'($urandom), 0, 0, 0, 0);
    for (int i = 0; i < 20; i++) step(1, 8'($urandom), 1, 0, 0, 0);
    chk("steady_count", 32'(count_s), 4);

    phase = "flush";
    for (int i = 0; i < 5; i++) step(1, 8'($urandom), 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) step(0, 8'h00, 1, 0, 0, 0);
    chk("pre_flush_count", 32'(count_s), 5);
    step(1, 8'h77, 0, 1, 0, 0);
    chk("flush_count", 32'(count_s), 0);
    chk("flush_ovf", 32'(ovf_s), 1);
    step(0, 8'h00, 0, 0, 1, 0);
    chk("errclr_ovf", 32'(ovf_s), 0);

    phase = "random";
    for (int i = 0; i < 400; i++)
      step(1'($urandom), 8'($urandom), 1'($urandom), ($urandom % 32) == 0,
           ($urandom % 16) == 0, ($urandom % 128) == 0);

    phase = "fwft";
    step(0, 8'h00, 0, 0, 0, 1);
    step(1, 8'h3C, 0, 0, 0, 0);
    chk("fwft_valid", 32'(rd_valid_f), 1);
    chk("fwft_data", 32'(rd_data_f), 32'h3C);
    chk("fwft_empty", 32'(empty_f), 0);
    step(1, 8'h3D, 0, 0, 0, 0);
    step(1, 8'h3E, 0, 0, 0, 0);
    chk("fwft_count3", 32'(count_f), 3);
    step(1, 8'h99, 1, 1, 1, 1);
    chk("rst_rdata_f", 32'(rd_data_f), 0);
    chk("rst_rvalid_f", 32'(rd_valid_f), 0);
    chk("rst_rdata_s", 32'(rd_data_s), 0);
    step(1, 8'h5A, 0, 0, 0, 0);
    chk("post_rst_wr", 32'(count_f), 1);
    chk("post_rst_data", 32'(rd_data_f), 32'h5A);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
